// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 8-bit shift/rotate controller, at most 7 positions per step.
// Optional SHIFT_SEQ_FASTPATH_EN: rotates use amount mod 8, saturating shifts finish at acceptance.
module shift_unit (
    input  logic [7:0] i_a,
    input  logic [2:0] i_op,
    input  logic [2:0] i_cnt,
    output logic [7:0] o_y
);
    logic [15:0] w_rl;
    logic [15:0] w_rr;
    assign w_rl = {i_a, i_a} << i_cnt;
    assign w_rr = {i_a, i_a} >> i_cnt;
    always_comb begin
        o_y = (i_op == 3'd1 || i_op == 3'd2) ? i_a << i_cnt :
              (i_op == 3'd3) ? i_a >> i_cnt :
              (i_op == 3'd4) ? 8'($signed(i_a) >>> i_cnt) :
              (i_op == 3'd5) ? w_rl[15:8] :
              (i_op == 3'd6) ? w_rr[7:0] : i_a;
    end
endmodule

module shift_sequencer #(
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [7:0]       d_in,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic [7:0]       d_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [7:0]       r_data, w_shift, w_load_data, w_rem_ext;
    logic [2:0]       r_op, w_step;
    logic [AMT_W-1:0] r_rem, w_rem_next, w_load_rem;
    logic             w_accept, w_pass, w_load_done;

    assign w_accept  = start_valid && r_state == IDLE;
    assign w_pass    = op == 3'd0 || op == 3'd7;
    assign w_rem_ext = 8'(r_rem);
    assign w_step    = (w_rem_ext > 8'd7) ? 3'd7 : w_rem_ext[2:0];
    assign w_rem_next = r_rem - AMT_W'(w_step);

`ifdef SHIFT_SEQ_FASTPATH_EN
    logic [7:0] w_amt_ext;
    logic       w_rot, w_sat;
    assign w_amt_ext = 8'(amount);
    assign w_rot     = op == 3'd5 || op == 3'd6;
    // Eight or more positions always flush a plain shift, so resolve it here.
    assign w_sat       = !w_pass && !w_rot && w_amt_ext >= 8'd8;
    assign w_load_rem  = w_rot ? AMT_W'(w_amt_ext[2:0]) : (w_sat ? '0 : amount);
    assign w_load_data = w_sat ? ((op == 3'd4) ? {8{d_in[7]}} : 8'h00) : d_in;
`else
    assign w_load_rem  = amount;
    assign w_load_data = d_in;
`endif
    assign w_load_done = w_pass || w_load_rem == '0;

    shift_unit u_shift (
        .i_a  (r_data),
        .i_op (r_op),
        .i_cnt(w_step),
        .o_y  (w_shift)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && start_valid)      w_next = w_load_done ? DONE : RUN;
        else if (r_state == RUN && w_rem_next == '0) w_next = DONE;
        else if (r_state == DONE && done_ready)  w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_op   <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_data <= w_load_data;
            r_op   <= op;
            r_rem  <= w_load_rem;
        end else if (r_state == RUN) begin
            r_data <= w_shift;
            r_rem  <= w_rem_next;
        end
    end

    assign start_ready = r_state == IDLE;
    assign done_valid  = r_state == DONE;
    assign busy        = r_state != IDLE;
    assign d_out       = r_data;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: random and directed commands scored against a saturating shift/rotate model.
module tb_shift_sequencer;
    localparam int AMT_W = 5;
    logic clk = 1'b0, rst = 1'b1;
    logic start_valid = 1'b0, done_ready = 1'b0;
    logic [7:0] d_in = 8'h00;
    logic [2:0] op_i = 3'd0;
    logic [AMT_W-1:0] amount = '0;
    logic start_ready, done_valid, busy;
    logic [7:0] d_out;

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .d_in(d_in), .op(op_i), .amount(amount), .d_out(d_out),
        .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; int cyc; } exp_t;
    exp_t q[$];
    int n_vec = 0, n_fail = 0, cyc = 0;
    logic prev_dv = 1'b0;
    logic [7:0] held = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ref_res(input logic [7:0] d, input logic [2:0] op, input int amt);
        int r;
        r = amt % 8;
        case (op)
            3'd1, 3'd2: return (amt >= 8) ? 8'h00 : 8'(d << amt);
            3'd3:       return (amt >= 8) ? 8'h00 : 8'(d >> amt);
            3'd4:       return (amt >= 8) ? {8{d[7]}} : 8'($signed(d) >>> amt);
            3'd5:       return 8'((d << r) | (d >> (8 - r)));
            3'd6:       return 8'((d >> r) | (d << (8 - r)));
            default:    return d;
        endcase
    endfunction

    function automatic int ref_steps(input logic [2:0] op, input int amt);
        if (op == 3'd0 || op == 3'd7 || amt == 0) return 0;
`ifdef SHIFT_SEQ_FASTPATH_EN
        if (op == 3'd5 || op == 3'd6) return (amt % 8 == 0) ? 0 : 1;
        return (amt >= 8) ? 0 : 1;
`else
        return (amt + 6) / 7;
`endif
    endfunction

    always @(negedge clk) begin
        if (rst) prev_dv = 1'b0;
        else begin
            if (done_valid && !prev_dv) begin
                if (q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("d_out", d_out, e.d);
                    chk("latency_cycle", cyc, e.cyc);
                    held = d_out;
                end
            end else if (done_valid) chk("d_out_hold", d_out, held);
            prev_dv = done_valid;
        end
    end

    task automatic run_cmd(input logic [7:0] d, input logic [2:0] op, input int amt, input int hold);
        int t;
        @(negedge clk);
        d_in = d; op_i = op; amount = AMT_W'(amt); start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        q.push_back('{ref_res(d, op, amt), cyc + ref_steps(op, amt)});
        t = 0;
        while (!done_valid && t < 100) begin @(negedge clk); t++; end
        if (!done_valid) begin chk("done_timeout", 0, 1); return; end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start_valid = (i == 0);
            d_in = 8'($urandom); op_i = 3'($urandom); amount = AMT_W'($urandom);
            chk("start_ready_in_done", start_ready, 0);
            chk("busy_in_done", busy, 1);
        end
        @(negedge clk);
        start_valid = 1'b0; done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        chk("idle_after_handshake", {busy, done_valid, start_ready}, 3'b001);
    endtask

    initial begin
        #1;
        chk("reset_start_ready", start_ready, 1);
        chk("reset_done_valid", done_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_d_out", d_out, 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_cmd(8'h9D, 3'd5, 2, 0);
        run_cmd(8'h9D, 3'd4, 10, 1);
        run_cmd(8'h9D, 3'd3, 3, 0);
        run_cmd(8'h9D, 3'd0, 5, 0);
        run_cmd(8'h9D, 3'd6, 16, 2);
        run_cmd(8'h9D, 3'd1, 0, 0);
        run_cmd(8'hB5, 3'd2, 31, 3);
        run_cmd(8'h9D, 3'd7, 9, 3);
        // Reset in the middle of a long left shift discards it.
        @(negedge clk);
        d_in = 8'hA7; op_i = 3'd1; amount = AMT_W'(20); start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_d_out", d_out, 8'h00);
        chk("rst_start_ready", start_ready, 1);
        chk("rst_done_valid", done_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd(8'h9D, 3'd5, 2, 0);
        for (int n = 0; n < 200; n++)
            run_cmd(8'($urandom), 3'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_fail);
        $fatal(1);
    end
endmodule
